// File: rtl/serial_pattern_tx_if.sv
// Handshake/line bundle for serial_pattern_tx; match_cnt exists only when TX_MATCH_COUNT_EN is defined.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             repeat_en;
  logic             x;
  logic             valid;
  logic             last;
  logic             busy;
  logic [1:0]       outstate;
`ifdef TX_MATCH_COUNT_EN
  logic [7:0]       match_cnt;

  modport master (output start, data, repeat_en,
                  input  x, valid, last, busy, outstate, match_cnt);
  modport slave  (input  start, data, repeat_en,
                  output x, valid, last, busy, outstate, match_cnt);
`else
  modport master (output start, data, repeat_en,
                  input  x, valid, last, busy, outstate);
  modport slave  (input  start, data, repeat_en,
                  output x, valid, last, busy, outstate);
`endif
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: MSB-first frames, optional repeat with GAP idle bits.
// Optional macro TX_MATCH_COUNT_EN adds a golden overlapping-1101 counter on the line.
module serial_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int GAP   = 2
) (
  input logic               clk,
  input logic               rst_n,
  serial_pattern_tx_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             accept;
  logic             reload;
  logic             gap_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reload    = 1'b0;
    gap_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == '0) begin
          if (!bus.repeat_en) begin
            state_nxt = ST_IDLE;
          end else if (GAP > 0) begin
            gap_load  = 1'b1;
            state_nxt = ST_GAP;
          end else begin
            reload    = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          reload    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counters stop at zero so they are always reloaded rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (accept) begin
        shift_reg <= bus.data;
        hold_reg  <= bus.data;
        bit_cnt   <= CNT_LOAD;
      end else if (reload) begin
        shift_reg <= hold_reg;
        bit_cnt   <= CNT_LOAD;
      end else if (state == ST_SHIFT) begin
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
      end
      if (gap_load) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  assign bus.x        = (state == ST_SHIFT) & shift_reg[WIDTH-1];
  assign bus.valid    = (state == ST_SHIFT);
  assign bus.last     = (state == ST_SHIFT) && (bit_cnt == '0);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.outstate = state;

`ifdef TX_MATCH_COUNT_EN
  logic [3:0] win;
  logic [3:0] win_nxt;
  logic [7:0] mcnt;

  // The pattern completing on the current bit is counted in that same cycle.
  assign win_nxt = {win[2:0], bus.x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win  <= '0;
      mcnt <= '0;
    end else if (accept) begin
      win  <= '0;
      mcnt <= '0;
    end else if (state != ST_IDLE) begin
      win <= win_nxt;
      if (win_nxt == 4'b1101 && mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
    end
  end

  assign bus.match_cnt = mcnt;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a GAP=2 and a GAP=0 instance checked against a frame-level model.
module tb_serial_pattern_tx;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(W)) b2 ();
  serial_pattern_tx_if #(.WIDTH(W)) b0 ();

  serial_pattern_tx #(.WIDTH(W), .GAP(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(b2));
  serial_pattern_tx #(.WIDTH(W), .GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int g, input logic s, input logic [W-1:0] d, input logic r);
    if (g == 0) begin
      b0.start = s; b0.data = d; b0.repeat_en = r;
    end else begin
      b2.start = s; b2.data = d; b2.repeat_en = r;
    end
  endtask

  task automatic sample(input int g, output logic [31:0] ox, output logic [31:0] ov,
                        output logic [31:0] ol, output logic [31:0] ob,
                        output logic [31:0] os, output logic [31:0] om);
    om = 0;
    if (g == 0) begin
      ox = 32'(b0.x); ov = 32'(b0.valid); ol = 32'(b0.last);
      ob = 32'(b0.busy); os = 32'(b0.outstate);
`ifdef TX_MATCH_COUNT_EN
      om = 32'(b0.match_cnt);
`endif
    end else begin
      ox = 32'(b2.x); ov = 32'(b2.valid); ol = 32'(b2.last);
      ob = 32'(b2.busy); os = 32'(b2.outstate);
`ifdef TX_MATCH_COUNT_EN
      om = 32'(b2.match_cnt);
`endif
    end
  endtask

  task automatic check_idle(input int g, input string tag);
    logic [31:0] ox, ov, ol, ob, os, om;
    sample(g, ox, ov, ol, ob, os, om);
    chk({tag, " x"}, ox, 0);
    chk({tag, " valid"}, ov, 0);
    chk({tag, " last"}, ol, 0);
    chk({tag, " busy"}, ob, 0);
    chk({tag, " outstate"}, os, 0);
  endtask

  // Caller has already driven start=1 with data d; the next edge accepts it.
  // Expected line: n frames of d, MSB first, separated by g zero cycles, then IDLE.
  task automatic run_frame(input int g, input logic [W-1:0] d, input int n,
                           input bit chain, input logic [W-1:0] nd);
    int          p, len, pos, cnt;
    logic [31:0] ox, ov, ol, ob, os, om;
    logic [31:0] ex, ev, el, eb, es;
    logic        r;
    bit          q[$];
    p   = W + g;
    len = n * W + (n - 1) * g;
    q.delete();
    for (int c = 0; c <= len; c++) begin
      @(posedge clk);
      #1;
      sample(g, ox, ov, ol, ob, os, om);
      pos = c % p;
      if (c == len) begin
        ex = 0; ev = 0; el = 0; es = 0;
      end else if (pos < W) begin
        ex = 32'(d[W-1-pos]); ev = 1; el = (pos == W - 1) ? 1 : 0; es = 1;
      end else begin
        ex = 0; ev = 0; el = 0; es = 2;
      end
      eb = (c < len) ? 1 : 0;
      if (c < len) q.push_back(ex[0]);
      chk($sformatf("x g%0d c%0d", g, c), ox, ex);
      chk($sformatf("valid g%0d c%0d", g, c), ov, ev);
      chk($sformatf("last g%0d c%0d", g, c), ol, el);
      chk($sformatf("busy g%0d c%0d", g, c), ob, eb);
      chk($sformatf("outstate g%0d c%0d", g, c), os, es);
      if (c < len) begin
        r = (pos == W - 1) ? (c < len - 1) : 1'($urandom);
        // start is offered at random while busy, and always on the edge ending the frame
        drive(g, (c == len - 1) ? 1'b1 : 1'($urandom), W'($urandom), r);
      end else if (chain) begin
        drive(g, 1'b1, nd, 1'($urandom));
      end else begin
        drive(g, 1'b0, W'($urandom), 1'b0);
      end
    end
`ifdef TX_MATCH_COUNT_EN
    cnt = 0;
    for (int i = 3; i < q.size(); i++)
      if (q[i-3] && q[i-2] && !q[i-1] && q[i]) cnt++;
    if (cnt > 255) cnt = 255;
    sample(g, ox, ov, ol, ob, os, om);
    chk($sformatf("match_cnt g%0d", g), om, 32'(cnt));
`else
    cnt = q.size();
`endif
  endtask

  initial begin
    logic [31:0] ox, ov, ol, ob, os, om;
    logic [W-1:0] d;
    int           g;
    rst_n = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    drive(2, 1'b0, '0, 1'b0);
    #12;
    check_idle(2, "reset g2");
    check_idle(0, "reset g0");
`ifdef TX_MATCH_COUNT_EN
    chk("reset match_cnt", 32'(b2.match_cnt), 0);
`endif
    rst_n = 1'b1;

    // Single-shot 1101 + zeros, then a start held past the final bit chains the next frame.
    drive(2, 1'b1, 16'hD000, 1'b0);
    run_frame(2, 16'hD000, 1, 1'b1, 16'hDDDD);
    run_frame(2, 16'hDDDD, 2, 1'b0, '0);
    check_idle(2, "post repeat g2");

    drive(0, 1'b1, 16'hDDDD, 1'b0);
    run_frame(0, 16'hDDDD, 2, 1'b0, '0);

    // Reset asserted during the 5th bit drops the line without waiting for an edge.
    drive(2, 1'b1, 16'hA5C3, 1'b1);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 16'hFFFF, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    sample(2, ox, ov, ol, ob, os, om);
    chk("bit5 x", ox, 0);
    chk("bit5 valid", ov, 1);
    chk("bit5 busy", ob, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle(2, "midframe reset");
`ifdef TX_MATCH_COUNT_EN
    chk("midframe reset match_cnt", 32'(b2.match_cnt), 0);
`endif
    #2;
    rst_n = 1'b1;
    drive(2, 1'b1, 16'h8001, 1'b0);
    run_frame(2, 16'h8001, 1, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 1) ? 0 : 2;
      d = W'($urandom);
      drive(g, 1'b1, d, 1'($urandom));
      run_frame(g, d, int'($urandom_range(1, 3)), 1'b0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
